// File: rtl/rom_word_writer.sv
// rom_word_writer: packs the ROM loader byte stream into little-endian 16-bit
// words, buffers them in a small FIFO and writes them to cartridge memory over
// a single-outstanding req/ack port. Reports busy/done, byte count, overflow.
module rom_word_writer #(
  parameter int ADDR_WIDTH = 21,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  input  logic                  loading,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Packing state: phase_reg=1 means a low (even) byte is pending in low_reg.
  logic       phase_reg;
  logic [7:0] low_reg;

  // Word FIFO: plain array so it maps onto RAM; the read is registered
  // straight into the write-port data register.
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic                  mem_req_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [15:0]           mem_wdata_reg;
  logic [ADDR_WIDTH:0]   byte_count_reg;
  logic                  overflow_reg;

  logic        accept;
  logic        pad_push;
  logic        push;
  logic [15:0] push_data;
  logic        pop;
  logic        fifo_full;
  logic        push_ok;
  logic        drop;
  logic        ack_ok;

  // Datapath strobes derived from the current state and inputs.
  always_comb begin
    accept    = (state_reg == S_LOAD) && din_valid;
    pad_push  = (state_reg == S_FLUSH) && phase_reg;
    push      = (accept && phase_reg) || pad_push;
    push_data = pad_push ? {8'hFF, low_reg} : {din, low_reg};
    pop       = !mem_req_reg && (count_reg != '0);
    fifo_full = (count_reg == FULL_COUNT);
    // A pop in the same cycle frees the slot, so that push is not a drop.
    push_ok   = push && (!fifo_full || pop);
    drop      = push && fifo_full && !pop;
    ack_ok    = mem_req_reg && mem_ack;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_WAIT;
    else       state_reg <= state_next;
  end

  // FSM next-state logic; DONE is terminal until reset.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_WAIT:  if (loading) state_next = S_LOAD;
      S_LOAD:  if (!loading) state_next = S_FLUSH;
      S_FLUSH: state_next = S_DRAIN;
      S_DRAIN: if ((count_reg == '0) && !mem_req_reg) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_WAIT;
    endcase
  end

  // Byte pairing: even byte waits in low_reg, odd byte completes the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= 1'b0;
      low_reg   <= 8'h00;
    end else if (accept) begin
      phase_reg <= ~phase_reg;
      if (!phase_reg) low_reg <= din;
    end else if (pad_push) begin
      phase_reg <= 1'b0;
    end
  end

  // FIFO storage write; no reset so it can live in RAM.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= push_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Write port: load a request from the FIFO head when idle, hold until ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_reg   <= 1'b0;
      mem_wdata_reg <= 16'h0000;
      mem_addr_reg  <= BASE;
    end else begin
      if (pop) begin
        mem_req_reg   <= 1'b1;
        mem_wdata_reg <= fifo_mem[rd_ptr_reg];
      end else if (ack_ok) begin
        mem_req_reg <= 1'b0;
      end
      // Address wraps naturally at 2^ADDR_WIDTH.
      if (ack_ok) mem_addr_reg <= mem_addr_reg + 1'b1;
    end
  end

  // Saturating byte counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (accept && (byte_count_reg != '1)) byte_count_reg <= byte_count_reg + 1'b1;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign byte_count = byte_count_reg;
  assign overflow   = overflow_reg;
  assign busy       = (state_reg == S_LOAD) || (state_reg == S_FLUSH) || (state_reg == S_DRAIN);
  assign done       = (state_reg == S_DONE);

endmodule

// File: tb/tb_rom_word_writer.sv
// Testbench for rom_word_writer: directed streams, scoreboard of expected
// memory writes, a configurable-latency memory responder, and a second
// instance with a 2-bit address for the wrap case.
module tb_rom_word_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       loading;

  // Main instance (default parameters).
  logic        mem_req, mem_ack, busy, done, overflow;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [21:0] byte_count;

  // Wrap instance (ADDR_WIDTH=2), zero-wait ack.
  logic        mem_req_w, mem_ack_w, busy_w, done_w, overflow_w;
  logic [1:0]  mem_addr_w;
  logic [15:0] mem_wdata_w;
  logic [2:0]  byte_count_w;

  rom_word_writer dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .loading(loading),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .byte_count(byte_count), .overflow(overflow)
  );

  rom_word_writer #(.ADDR_WIDTH(2), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .loading(loading),
    .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .mem_ack(mem_ack_w),
    .busy(busy_w), .done(done_w), .byte_count(byte_count_w), .overflow(overflow_w)
  );

  typedef struct packed {
    logic [20:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t q_main[$];
  wr_t q_w[$];

  int total = 0;
  int bad = 0;
  int drops = 0;
  int slow_addr = 0;
  bit allow_drop = 1'b0;
  bit w_chk = 1'b0;
  bit ack_en = 1'b1;
  int ack_lat = 0;
  int wait_cnt = 0;

  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [20:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  // Memory responder: ack ack_lat cycles after the request rose.
  assign mem_ack   = ack_en && mem_req && (wait_cnt >= ack_lat);
  assign mem_ack_w = mem_req_w;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: scoreboard compare on accepted writes, hold check.
  task automatic monitor();
    wr_t e;
    logic [20:0] exp_a;
    if (!reset && mem_req && mem_ack) begin
      while (allow_drop && (q_main.size() > 0) && (q_main[0].data !== mem_wdata)) begin
        void'(q_main.pop_front());
        drops++;
      end
      total++;
      assert (q_main.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%0h@%0h expected=none", mem_wdata, mem_addr);
      end
      if (q_main.size() > 0) begin
        e = q_main.pop_front();
        exp_a = allow_drop ? 21'(slow_addr) : e.addr;
        slow_addr++;
        total++;
        assert ({mem_addr, mem_wdata} === {exp_a, e.data}) else begin
          bad++;
          $error("FAIL write observed=%0h@%0h expected=%0h@%0h", mem_wdata, mem_addr, e.data, exp_a);
        end
      end
    end
    if (!reset && mem_req && prev_req && !prev_ack) begin
      total++;
      assert ({mem_addr, mem_wdata} === {prev_addr, prev_data}) else begin
        bad++;
        $error("FAIL req_hold observed=%0h@%0h expected=%0h@%0h", mem_wdata, mem_addr, prev_data, prev_addr);
      end
    end
    prev_req  = mem_req && !reset;
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
    prev_data = mem_wdata;

    if (w_chk && !reset && mem_req_w && mem_ack_w) begin
      total++;
      assert (q_w.size() > 0) else begin
        bad++;
        $error("FAIL wrap_unexpected observed=%0h@%0h expected=none", mem_wdata_w, mem_addr_w);
      end
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        total++;
        assert ({21'(mem_addr_w), mem_wdata_w} === {e.addr, e.data}) else begin
          bad++;
          $error("FAIL wrap_write observed=%0h@%0h expected=%0h@%0h", mem_wdata_w, mem_addr_w, e.data, e.addr);
        end
      end
    end
  endtask

  // One clock cycle: monitor at the falling edge, return 1 after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
  endtask

  task automatic start_stream();
    loading = 1'b1;
    tick();
  endtask

  task automatic end_stream();
    loading = 1'b0;
    tick();
  endtask

  task automatic expect_wr(input int a, input logic [15:0] d);
    q_main.push_back({21'(a), d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    loading = 1'b0;
    din_valid = 1'b0;
    tick();
    reset = 1'b0;
    q_main.delete();
    q_w.delete();
    slow_addr = 0;
    tick();
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((done !== 1'b1) && (n < bound)) begin
      tick();
      n++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_byte_count"}, 64'(byte_count), 64'd0);
    chk({pfx, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    logic [7:0] lo;
    reset = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    loading = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    $display("txn: reset checked");
    reset = 1'b0;
    tick();

    // Even stream, zero-wait ack, with request latency check on the first word.
    ack_lat = 0;
    start_stream();
    expect_wr(0, 16'h2211);
    expect_wr(1, 16'h4433);
    send_byte(8'h11);
    din = 8'h22;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("req_at_T1", 64'(mem_req), 64'd0);
    chk("busy_in_load", 64'(busy), 64'd1);
    tick();
    chk("req_at_T2", 64'(mem_req), 64'd1);
    tick();
    send_byte(8'h33);
    send_byte(8'h44);
    end_stream();
    wait_done(200);
    chk("even_byte_count", 64'(byte_count), 64'd4);
    chk("even_overflow", 64'(overflow), 64'd0);
    chk("even_busy", 64'(busy), 64'd0);
    chk("even_drained", 64'(q_main.size()), 64'd0);
    $display("txn: even stream 11 22 33 44 done");

    // Odd tail gets an FF pad.
    do_reset();
    start_stream();
    expect_wr(0, 16'hBBAA);
    expect_wr(1, 16'hFFCC);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    end_stream();
    wait_done(200);
    chk("odd_byte_count", 64'(byte_count), 64'd3);
    chk("odd_drained", 64'(q_main.size()), 64'd0);
    $display("txn: odd tail AA BB CC done");

    // Final odd byte on the same cycle loading falls: paired, no pad.
    do_reset();
    start_stream();
    expect_wr(0, 16'h0201);
    expect_wr(1, 16'h0403);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    din = 8'h04;
    din_valid = 1'b1;
    loading = 1'b0;
    tick();
    din_valid = 1'b0;
    wait_done(200);
    repeat (4) tick();
    chk("same_byte_count", 64'(byte_count), 64'd4);
    chk("same_drained", 64'(q_main.size()), 64'd0);
    chk("same_done_sticky", 64'(done), 64'd1);
    $display("txn: same-cycle tail done");

    // Slow memory: overflow on the first dropped word, holds and order checked.
    do_reset();
    ack_lat = 20;
    allow_drop = 1'b1;
    drops = 0;
    start_stream();
    for (int j = 0; j < 12; j++) begin
      lo = 8'(2 * j + 1);
      q_main.push_back({21'd0, lo + 8'd1, lo});
    end
    for (int i = 0; i < 24; i++) begin
      send_byte(8'(i + 1));
      if (i == 9)  chk("ovf_before_drop", 64'(overflow), 64'd0);
      if (i == 11) chk("ovf_after_drop", 64'(overflow), 64'd1);
    end
    end_stream();
    wait_done(2000);
    chk("slow_overflow", 64'(overflow), 64'd1);
    chk("slow_byte_count", 64'(byte_count), 64'd24);
    chk("slow_drops_seen", 64'(drops > 0), 64'd1);
    allow_drop = 1'b0;
    q_main.delete();
    $display("txn: slow memory done, writes=%0d drops=%0d", slow_addr, drops);

    // Reset with a request outstanding and words queued.
    do_reset();
    ack_lat = 0;
    ack_en = 1'b0;
    start_stream();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h61 + i));
    chk("mid_req_pending", 64'(mem_req), 64'd1);
    reset = 1'b1;
    loading = 1'b0;
    tick();
    check_reset_vals("mid_reset");
    reset = 1'b0;
    q_main.delete();
    ack_en = 1'b1;
    ack_lat = 3;
    tick();
    start_stream();
    expect_wr(0, 16'hA55A);
    expect_wr(1, 16'h3CC3);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'hC3);
    send_byte(8'h3C);
    end_stream();
    wait_done(300);
    chk("restart_byte_count", 64'(byte_count), 64'd4);
    chk("restart_drained", 64'(q_main.size()), 64'd0);
    $display("txn: reset mid-operation and restart done");

    // Address wrap on the 2-bit instance; main instance sees the same stream.
    do_reset();
    ack_lat = 0;
    w_chk = 1'b1;
    start_stream();
    for (int j = 0; j < 5; j++) begin
      lo = 8'(8'h10 + 2 * j);
      q_main.push_back({21'(j), lo + 8'd1, lo});
      q_w.push_back({21'(j % 4), lo + 8'd1, lo});
    end
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
    end_stream();
    wait_done(300);
    repeat (2) tick();
    chk("wrap_done", 64'(done_w), 64'd1);
    chk("wrap_overflow", 64'(overflow_w), 64'd0);
    chk("wrap_byte_count_sat", 64'(byte_count_w), 64'd7);
    chk("wrap_drained", 64'(q_w.size()), 64'd0);
    chk("wrap_main_byte_count", 64'(byte_count), 64'd10);
    chk("wrap_main_drained", 64'(q_main.size()), 64'd0);
    w_chk = 1'b0;
    $display("txn: address wrap done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
